// File: rtl/axis_upsizer_pkg.sv
// Shared helpers for the narrow-to-wide AXI4-Stream packer.
package axis_upsizer_pkg;

  // Lane counter width; a single-lane configuration still needs one bit.
  function automatic int unsigned cntr_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/axis_upsizer_out_reg.sv
// Data/last register slice with valid/ready, used as the packer's output stage.
module axis_upsizer_out_reg #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             can_load
);

  assign can_load = ~valid | ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      // A load in the same cycle as a handshake keeps valid high.
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_upsizer.sv
// Packs narrow AXI4-Stream beats into wide words, lane 0 first, with a run-time
// lane count and early flush on s_axis_tlast.
module axis_upsizer
  import axis_upsizer_pkg::*;
#(
  parameter int unsigned S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned M_AXIS_TDATA_WIDTH = 128
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [15:0]                   cfg_data,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready
);

  localparam int unsigned S          = S_AXIS_TDATA_WIDTH;
  localparam int unsigned M          = M_AXIS_TDATA_WIDTH;
  localparam int unsigned RATIO      = M / S;
  localparam int unsigned CNTR_WIDTH = cntr_width(RATIO);

  logic [CNTR_WIDTH-1:0] cntr;
  logic [CNTR_WIDTH-1:0] cfg_lanes;
  logic [M-1:0]          acc;
  logic [M-1:0]          acc_next;
  logic [M-1:0]          word_next;
  logic                  last;
  logic                  accept;
  logic                  close;
  logic                  can_load;
  logic                  unused_cfg;

  assign cfg_lanes  = cfg_data[CNTR_WIDTH-1:0];
  assign unused_cfg = ^cfg_data[15:CNTR_WIDTH];

  // The top-lane term keeps the counter in range when cfg exceeds RATIO-1.
  assign last = (cntr >= cfg_lanes) || (cntr == CNTR_WIDTH'(RATIO - 1)) || s_axis_tlast;

  assign s_axis_tready = last ? can_load : 1'b1;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign close         = accept & last;

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    logic hit;
    assign hit = (cntr == CNTR_WIDTH'(i));
    assign word_next[i*S +: S] = hit ? s_axis_tdata : acc[i*S +: S];
    assign acc_next[i*S +: S]  = close          ? '0           :
                                 (accept && hit) ? s_axis_tdata : acc[i*S +: S];
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cntr <= '0;
      acc  <= '0;
    end else begin
      acc <= acc_next;
      if (close) begin
        cntr <= '0;
      end else if (accept) begin
        cntr <= cntr + 1'b1;
      end
    end
  end

  axis_upsizer_out_reg #(
    .WIDTH(M)
  ) u_out_reg (
    .clk      (aclk),
    .rst      (areset),
    .load     (close),
    .load_data(word_next),
    .load_last(s_axis_tlast),
    .ready    (m_axis_tready),
    .valid    (m_axis_tvalid),
    .data     (m_axis_tdata),
    .last     (m_axis_tlast),
    .can_load (can_load)
  );

endmodule

// File: doc/axis_upsizer.md
# axis_upsizer

Packs a stream of narrow AXI4-Stream words into wide words, lane 0 first, with a run-time lane count and early flush on `s_axis_tlast`. It sits upstream of `axis_downsizer`, or in front of a DMA/FIFO, and restores the wide-word view from a narrow sample stream. It sustains one input beat per clock while the consumer keeps up.

## Interface
Parameters:
- `S_AXIS_TDATA_WIDTH`, 32, narrow input word width.
- `M_AXIS_TDATA_WIDTH`, 128, wide output word width; an integer multiple of the input width.
- Derived localparams:
  - `RATIO = M/S`.
  - `CNTR_WIDTH = RATIO > 1 ? clog2(RATIO) : 1`.

Ports:
- `aclk`  in  1  sole clock; everything is on its rising edge.
- `areset`  in  1  reset, synchronous, active-high.
- `cfg_data`  in  16  lanes per output word minus 1; only bits [CNTR_WIDTH-1:0] are used.
- `s_axis_tdata`  in  S  narrow input word.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tlast`  in  1  end of packet; forces emission of a partial word.
- `s_axis_tready`  out  1  input ready.
- `m_axis_tdata`  out  M  wide output word.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tlast`  out  1  set on the word closed by `s_axis_tlast`.
- `m_axis_tready`  in  1  output ready.

## Operation
- State:
  - lane counter `cntr` (CNTR_WIDTH bits);
  - accumulator `acc` (M bits);
  - output register `out_data` / `out_valid` / `out_last`.
- `last = (cntr >= cfg_data[CNTR_WIDTH-1:0]) | s_axis_tlast`. Using `>=` means a mid-word reduction of `cfg_data` closes the word on the next beat; the block never stalls waiting for a wrap.
- `s_axis_tready = last ? (~out_valid | m_axis_tready) : 1`.
- Accepted non-last beat:
  - `acc[cntr*S +: S] <= s_axis_tdata`;
  - `cntr <= cntr + 1`.
- Accepted last beat:
  - `out_data <= acc` with lane `cntr` replaced by `s_axis_tdata`;
  - `out_valid <= 1`;
  - `out_last <= s_axis_tlast`;
  - `acc <= 0`;
  - `cntr <= 0`.
- Lanes above the closing lane are always zero, because `acc` is cleared at every emission and at reset.
- Output handshake: `out_valid` clears on `m_axis_tvalid & m_axis_tready` unless a new last beat is accepted in the same cycle, in which case it stays set and is reloaded.
- `m_axis_*` are driven directly from the output register; there is no combinational path from `s_axis_*` to `m_axis_*`.
- RATIO = 1: every beat is last and the block acts as a one-deep register slice.
- Reset mid-word discards the partial word and any pending output word.

## Timing
- Reset values: `cntr = 0`, `acc = 0`, `m_axis_tvalid = 0`, `m_axis_tlast = 0`, `m_axis_tdata = 0`.
- `s_axis_tready = 1` in the first cycle after reset.
- Latency: `m_axis_tvalid` rises on the clock after the last beat of a word is accepted.
- Throughput: one input beat per cycle while `m_axis_tready` stays high; back-to-back output words are possible every `cfg+1` cycles.
- Backpressure:
  - Only a last beat waits on the output register.
  - Non-last beats are always accepted, so up to `cfg` lanes of the next word fill while the previous word is held.
- `m_axis_tdata` and `m_axis_tlast` are stable while `m_axis_tvalid & ~m_axis_tready`.
- `cfg_data` is sampled every cycle with no latching. Changing it mid-word affects only the `last` decision; lanes already written are kept.

## Structure
- No shared package is needed. RATIO and CNTR_WIDTH are localparams.
- One sub-module is natural: `axis_upsizer_out_reg`, a data/last register slice with valid/ready, load enable and `can_load = ~valid | ready`.
- Counter, accumulator and lane-write decode stay in the top module, using a generate loop over lanes.

## Test plan
S=32, M=128 unless noted.
- **Full word.** cfg=3; beats 0x11, 0x22, 0x33, 0x44 with `m_axis_tready = 1` → one word 0x00000044_00000033_00000022_00000011, tlast=0, valid one cycle after the 4th beat.
- **Short word.** cfg=1; beats A, B, C, D → words 0x0…_B_A and 0x0…_D_C, upper two lanes zero.
- **Early flush.** cfg=3; beats 1, 2 with tlast on beat 2 → word 0x0_0_2_1, tlast=1; the next beat lands in lane 0.
- **Backpressure.** cfg=3; `m_axis_tready = 0` after the first word → three more beats accepted, 4th beat stalled (tready=0) until the first word is taken; both words exact and output stable while stalled.
- **Config change and reset.**
  - cfg 3→0 after 2 beats → next beat closes the word (3 lanes).
  - `areset` asserted after 2 beats of a new word → no output; the following four beats form a clean word.
- **RATIO=1** (S=M=32): random valid/ready → output equals input sequence, one-cycle latency, no drops.
